// File: rtl/fir_xifu_pkg.sv
// fir_xifu_pkg
// Shared types and constants for the FIR XIFU in-flight instruction controller.
//   - fir_xifu_slot_state_e : lifecycle of one slot-table entry
//   - fir_xifu_slot_t       : one slot-table entry (state, id, rd, rd_we)
// Slot ids are stored at XIFU_ID_W_MAX bits so the struct does not depend on
// the controller's ID_W parameter; ids are zero-extended on capture and compare.
package fir_xifu_pkg;

    localparam int XIFU_NSLOTS_DEF = 4;
    localparam int XIFU_ID_W_MAX   = 8;   // upper bound for ID_W
    localparam int XIFU_REG_W      = 5;   // XIFU register index width (NREG <= 32)

    typedef enum logic [1:0] {
        SLOT_FREE      = 2'd0,
        SLOT_ISSUED    = 2'd1,
        SLOT_COMMITTED = 2'd2,
        SLOT_DONE      = 2'd3
    } fir_xifu_slot_state_e;

    typedef struct packed {
        fir_xifu_slot_state_e     state;
        logic [XIFU_ID_W_MAX-1:0] id;
        logic [XIFU_REG_W-1:0]    rd;
        logic                     rd_we;
    } fir_xifu_slot_t;

endpackage

// File: rtl/fir_xifu_scoreboard.sv
// fir_xifu_scoreboard
// Purely combinational issue check for the FIR XIFU controller.
//   slots_i          : registered slot table
//   req_*            : id and register usage of the instruction at decode
//   ready_o          : 1 when a slot is free, the id is not in flight and no
//                      in-flight writer targets a register the request uses
//   free_idx_o       : lowest-index FREE slot (valid only when a slot is free)
module fir_xifu_scoreboard
    import fir_xifu_pkg::*;
#(
    parameter int N_SLOTS = XIFU_NSLOTS_DEF,
    parameter int ID_W    = 4,
    parameter int REG_W   = 5
) (
    input  fir_xifu_slot_t             slots_i [N_SLOTS],
    input  logic [ID_W-1:0]            req_id_i,
    input  logic [REG_W-1:0]           req_rd_i,
    input  logic [REG_W-1:0]           req_rs1_i,
    input  logic [REG_W-1:0]           req_rs2_i,
    input  logic                       req_rd_we_i,
    input  logic                       req_rs1_re_i,
    input  logic                       req_rs2_re_i,
    output logic                       ready_o,
    output logic [$clog2(N_SLOTS)-1:0] free_idx_o
);

    localparam int IDX_W = $clog2(N_SLOTS);

    logic full;
    logic id_clash;
    logic hazard;

    always_comb begin
        // NOTE: every variable driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        full       = 1'b1;
        id_clash   = 1'b0;
        hazard     = 1'b0;
        free_idx_o = '0;
        // Walk downwards so the last FREE hit, the lowest index, wins.
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (slots_i[i].state == SLOT_FREE) begin
                full       = 1'b0;
                free_idx_o = IDX_W'(i);
            end else begin
                if (slots_i[i].id == XIFU_ID_W_MAX'(req_id_i)) begin
                    id_clash = 1'b1;
                end
                // RAW on either source, WAW on the destination.
                if (slots_i[i].rd_we &&
                    ((req_rs1_re_i && slots_i[i].rd == XIFU_REG_W'(req_rs1_i)) ||
                     (req_rs2_re_i && slots_i[i].rd == XIFU_REG_W'(req_rs2_i)) ||
                     (req_rd_we_i  && slots_i[i].rd == XIFU_REG_W'(req_rd_i)))) begin
                    hazard = 1'b1;
                end
            end
        end
        ready_o = !(full || id_clash || hazard);
    end

endmodule

// File: rtl/fir_xifu_ctrl.sv
// fir_xifu_ctrl
// In-flight instruction controller for the FIR XIFU coprocessor. Keeps a slot
// table of accepted instructions, gates XIF issue_ready through the
// scoreboard, retires slots on commit/kill and datapath writeback, and
// broadcasts a one-cycle kill to the pipeline.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   clear_i              : synchronous flush of every slot (no kill pulse)
//   issue_*              : XIF issue request and decoded register usage
//   issue_ready_o        : combinational issue_ready
//   commit_*             : XIF commit (optionally a kill)
//   wb_valid_i, wb_id_i  : datapath completion
//   kill_valid_o/_id_o   : registered flush pulse for ID/EX/WB
//   outstanding_o, busy_o: registered count of non-FREE slots
//   err_o                : registered pulse for commit/wb to an unknown id
module fir_xifu_ctrl
    import fir_xifu_pkg::*;
#(
    parameter int N_SLOTS = XIFU_NSLOTS_DEF,  // 2..8
    parameter int ID_W    = 4,                // <= XIFU_ID_W_MAX
    parameter int NREG    = 32                // <= 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         issue_valid_i,
    input  logic                         issue_accept_i,
    input  logic [ID_W-1:0]              issue_id_i,
    input  logic [$clog2(NREG)-1:0]      issue_rd_i,
    input  logic [$clog2(NREG)-1:0]      issue_rs1_i,
    input  logic [$clog2(NREG)-1:0]      issue_rs2_i,
    input  logic                         issue_rd_we_i,
    input  logic                         issue_rs1_re_i,
    input  logic                         issue_rs2_re_i,
    output logic                         issue_ready_o,
    input  logic                         commit_valid_i,
    input  logic [ID_W-1:0]              commit_id_i,
    input  logic                         commit_kill_i,
    input  logic                         wb_valid_i,
    input  logic [ID_W-1:0]              wb_id_i,
    output logic                         kill_valid_o,
    output logic [ID_W-1:0]              kill_id_o,
    output logic [$clog2(N_SLOTS+1)-1:0] outstanding_o,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int REG_W = $clog2(NREG);
    localparam int IDX_W = $clog2(N_SLOTS);
    localparam int CNT_W = $clog2(N_SLOTS + 1);

    fir_xifu_slot_t   slots_q [N_SLOTS];
    fir_xifu_slot_t   slots_d [N_SLOTS];
    logic             kill_valid_q, kill_valid_d;
    logic [ID_W-1:0]  kill_id_q, kill_id_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0] free_idx;
    logic             issue_fire;
    logic             commit_hit [N_SLOTS];
    logic             wb_hit     [N_SLOTS];
    logic             commit_known;
    logic             wb_known;

    fir_xifu_scoreboard #(
        .N_SLOTS (N_SLOTS),
        .ID_W    (ID_W),
        .REG_W   (REG_W)
    ) u_scoreboard (
        .slots_i      (slots_q),
        .req_id_i     (issue_id_i),
        .req_rd_i     (issue_rd_i),
        .req_rs1_i    (issue_rs1_i),
        .req_rs2_i    (issue_rs2_i),
        .req_rd_we_i  (issue_rd_we_i),
        .req_rs1_re_i (issue_rs1_re_i),
        .req_rs2_re_i (issue_rs2_re_i),
        .ready_o      (issue_ready_o),
        .free_idx_o   (free_idx)
    );

    // A handshake coinciding with clear_i is dropped.
    assign issue_fire = issue_valid_i && issue_accept_i && issue_ready_o && !clear_i;

    // Id matches against the registered table; FREE slots never match.
    always_comb begin
        commit_known = 1'b0;
        wb_known     = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            commit_hit[i] = commit_valid_i && (slots_q[i].state != SLOT_FREE) &&
                            (slots_q[i].id == XIFU_ID_W_MAX'(commit_id_i));
            wb_hit[i]     = wb_valid_i && (slots_q[i].state != SLOT_FREE) &&
                            (slots_q[i].id == XIFU_ID_W_MAX'(wb_id_i));
            commit_known  = commit_known || commit_hit[i];
            wb_known      = wb_known || wb_hit[i];
        end
    end

    always_comb begin
        slots_d       = slots_q;
        kill_valid_d  = 1'b0;
        kill_id_d     = '0;
        outstanding_d = '0;
        err_d         = 1'b0;

        if (clear_i) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slots_d[i].state = SLOT_FREE;
            end
        end else begin
            err_d = (commit_valid_i && !commit_known) || (wb_valid_i && !wb_known);
            for (int i = 0; i < N_SLOTS; i++) begin
                if (commit_hit[i] && commit_kill_i) begin
                    // Kill beats a simultaneous writeback of the same id.
                    slots_d[i].state = SLOT_FREE;
                    kill_valid_d     = 1'b1;
                    kill_id_d        = commit_id_i;
                end else begin
                    case (slots_q[i].state)
                        SLOT_ISSUED: begin
                            if (commit_hit[i] && wb_hit[i]) slots_d[i].state = SLOT_FREE;
                            else if (commit_hit[i])         slots_d[i].state = SLOT_COMMITTED;
                            else if (wb_hit[i])             slots_d[i].state = SLOT_DONE;
                        end
                        SLOT_COMMITTED: if (wb_hit[i])     slots_d[i].state = SLOT_FREE;
                        SLOT_DONE:      if (commit_hit[i]) slots_d[i].state = SLOT_FREE;
                        default: ;
                    endcase
                end
            end
            // The allocated slot was FREE in slots_q, so no retire touched it.
            if (issue_fire) begin
                slots_d[free_idx].state = SLOT_ISSUED;
                slots_d[free_idx].id    = XIFU_ID_W_MAX'(issue_id_i);
                slots_d[free_idx].rd    = XIFU_REG_W'(issue_rd_i);
                slots_d[free_idx].rd_we = issue_rd_we_i;
            end
        end

        for (int i = 0; i < N_SLOTS; i++) begin
            if (slots_d[i].state != SLOT_FREE) outstanding_d = outstanding_d + CNT_W'(1);
        end
        busy_d = (outstanding_d != '0);
    end

    // NOTE: the slot table is only a handful of flops and its state must be
    // FREE out of reset, so it is reset like any other register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slots_q[i] <= '{state: SLOT_FREE, id: '0, rd: '0, rd_we: 1'b0};
            end
            kill_valid_q  <= 1'b0;
            kill_id_q     <= '0;
            outstanding_q <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            slots_q       <= slots_d;
            kill_valid_q  <= kill_valid_d;
            kill_id_q     <= kill_id_d;
            outstanding_q <= outstanding_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign kill_valid_o  = kill_valid_q;
    assign kill_id_o     = kill_id_q;
    assign outstanding_o = outstanding_q;
    assign busy_o        = busy_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// tb_fir_xifu_ctrl
// Directed scenarios plus a randomized run for fir_xifu_ctrl. The reference
// model is a plain queue of in-flight instructions with committed/done flags.
module tb_fir_xifu_ctrl;

    localparam int N_SLOTS = 4;
    localparam int ID_W    = 4;
    localparam int NREG    = 32;
    localparam int CNT_W   = $clog2(N_SLOTS + 1);

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             clear_i;
    logic             issue_valid_i, issue_accept_i;
    logic [ID_W-1:0]  issue_id_i;
    logic [4:0]       issue_rd_i, issue_rs1_i, issue_rs2_i;
    logic             issue_rd_we_i, issue_rs1_re_i, issue_rs2_re_i;
    logic             issue_ready_o;
    logic             commit_valid_i;
    logic [ID_W-1:0]  commit_id_i;
    logic             commit_kill_i;
    logic             wb_valid_i;
    logic [ID_W-1:0]  wb_id_i;
    logic             kill_valid_o;
    logic [ID_W-1:0]  kill_id_o;
    logic [CNT_W-1:0] outstanding_o;
    logic             busy_o;
    logic             err_o;

    always #5 clk_i = ~clk_i;

    fir_xifu_ctrl #(.N_SLOTS(N_SLOTS), .ID_W(ID_W), .NREG(NREG)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .issue_valid_i  (issue_valid_i),
        .issue_accept_i (issue_accept_i),
        .issue_id_i     (issue_id_i),
        .issue_rd_i     (issue_rd_i),
        .issue_rs1_i    (issue_rs1_i),
        .issue_rs2_i    (issue_rs2_i),
        .issue_rd_we_i  (issue_rd_we_i),
        .issue_rs1_re_i (issue_rs1_re_i),
        .issue_rs2_re_i (issue_rs2_re_i),
        .issue_ready_o  (issue_ready_o),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .wb_valid_i     (wb_valid_i),
        .wb_id_i        (wb_id_i),
        .kill_valid_o   (kill_valid_o),
        .kill_id_o      (kill_id_o),
        .outstanding_o  (outstanding_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    // Reference model: one entry per in-flight instruction.
    typedef struct {
        int id;
        int rd;
        bit rd_we;
        bit c;   // committed
        bit d;   // written back
        bit k;   // killed
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   exp_kill;
    int   exp_kill_id;
    bit   exp_err;

    function automatic bit model_ready();
        if (q.size() >= N_SLOTS) return 1'b0;
        foreach (q[i]) begin
            if (q[i].id == int'(issue_id_i)) return 1'b0;
            if (q[i].rd_we && ((issue_rs1_re_i && q[i].rd == int'(issue_rs1_i)) ||
                               (issue_rs2_re_i && q[i].rd == int'(issue_rs2_i)) ||
                               (issue_rd_we_i  && q[i].rd == int'(issue_rd_i))))
                return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic idle();
        clear_i = 0; issue_valid_i = 0; issue_accept_i = 0; issue_id_i = '0;
        issue_rd_i = '0; issue_rs1_i = '0; issue_rs2_i = '0;
        issue_rd_we_i = 0; issue_rs1_re_i = 0; issue_rs2_re_i = 0;
        commit_valid_i = 0; commit_id_i = '0; commit_kill_i = 0;
        wb_valid_i = 0; wb_id_i = '0;
    endtask

    task automatic issue(input int id, input int rd, input bit we,
                         input int rs1, input bit re1, input int rs2, input bit re2);
        issue_valid_i = 1; issue_accept_i = 1; issue_id_i = ID_W'(id);
        issue_rd_i = 5'(rd); issue_rd_we_i = we;
        issue_rs1_i = 5'(rs1); issue_rs1_re_i = re1;
        issue_rs2_i = 5'(rs2); issue_rs2_re_i = re2;
    endtask

    // One clock edge with the model advanced from the pre-edge inputs.
    task automatic tick();
        bit   hs;
        int   ci, wi;
        ent_t e;
        hs = issue_valid_i && issue_accept_i && model_ready();
        @(posedge clk_i);
        exp_kill = 0; exp_kill_id = 0; exp_err = 0;
        if (clear_i) begin
            q.delete();
        end else begin
            ci = -1; wi = -1;
            foreach (q[i]) begin
                if (commit_valid_i && q[i].id == int'(commit_id_i)) ci = i;
                if (wb_valid_i && q[i].id == int'(wb_id_i)) wi = i;
            end
            exp_err = (commit_valid_i && ci < 0) || (wb_valid_i && wi < 0);
            if (ci >= 0) begin
                if (commit_kill_i) begin
                    q[ci].k = 1; exp_kill = 1; exp_kill_id = int'(commit_id_i);
                end else begin
                    q[ci].c = 1;
                end
            end
            if (wi >= 0) q[wi].d = 1;
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].k || (q[i].c && q[i].d)) q.delete(i);
            if (hs) begin
                e.id = int'(issue_id_i); e.rd = int'(issue_rd_i); e.rd_we = issue_rd_we_i;
                e.c = 0; e.d = 0; e.k = 0;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        idle();
        #12;
        n_checks++;
        if ({issue_ready_o, kill_valid_o, kill_id_o, outstanding_o, busy_o, err_o} !==
            {1'b1, 1'b0, {ID_W{1'b0}}, {CNT_W{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%0b kv=%0b kid=%0d out=%0d busy=%0b err=%0b want 1 0 0 0 0 0",
                     issue_ready_o, kill_valid_o, kill_id_o, outstanding_o, busy_o, err_o);
        end
        @(negedge clk_i);
        rst_ni = 1;
        q.delete();
    endtask

    task automatic test_basic();
        idle();
        issue(1, 3, 1, 1, 1, 2, 1);
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL basic_ready: got %0b want 1", issue_ready_o);
        end
        tick();
        n_checks++;
        if ({outstanding_o, busy_o} !== {CNT_W'(1), 1'b1}) begin
            n_fail++; $display("FAIL basic_issue_out: got out=%0d busy=%0b want 1 1", outstanding_o, busy_o);
        end
        idle(); commit_valid_i = 1; commit_id_i = 4'd1;
        tick();
        n_checks++;
        if ({outstanding_o, err_o} !== {CNT_W'(1), 1'b0}) begin
            n_fail++; $display("FAIL basic_commit: got out=%0d err=%0b want 1 0", outstanding_o, err_o);
        end
        idle(); wb_valid_i = 1; wb_id_i = 4'd1;
        tick();
        n_checks++;
        if ({outstanding_o, busy_o, err_o} !== {CNT_W'(0), 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL basic_retire: got out=%0d busy=%0b err=%0b want 0 0 0", outstanding_o, busy_o, err_o);
        end
    endtask

    task automatic test_raw_hazard();
        idle(); issue(6, 3, 1, 0, 0, 0, 0);
        tick();
        idle(); issue(7, 9, 1, 3, 1, 0, 0);
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL raw_blocked: got %0b want 0", issue_ready_o);
        end
        commit_valid_i = 1; commit_id_i = 4'd6;
        tick();
        commit_valid_i = 0;
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL raw_after_commit: got %0b want 0", issue_ready_o);
        end
        wb_valid_i = 1; wb_id_i = 4'd6;
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL raw_no_bypass: got %0b want 0", issue_ready_o);
        end
        tick();
        wb_valid_i = 0;
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL raw_released: got %0b want 1", issue_ready_o);
        end
        tick();
        n_checks++;
        if (outstanding_o !== CNT_W'(1)) begin
            n_fail++; $display("FAIL raw_accepted: got out=%0d want 1", outstanding_o);
        end
        idle(); commit_valid_i = 1; commit_id_i = 4'd7; wb_valid_i = 1; wb_id_i = 4'd7;
        tick();
        n_checks++;
        if ({outstanding_o, err_o} !== {CNT_W'(0), 1'b0}) begin
            n_fail++; $display("FAIL raw_cleanup: got out=%0d err=%0b want 0 0", outstanding_o, err_o);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            idle(); issue(i, 10 + i, 1, 20 + i, 1, 24 + i, 1);
            #1;
            n_checks++;
            if (issue_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL full_fill_ready: id=%0d got %0b want 1", i, issue_ready_o);
            end
            tick();
        end
        n_checks++;
        if (outstanding_o !== CNT_W'(4)) begin
            n_fail++; $display("FAIL full_count: got out=%0d want 4", outstanding_o);
        end
        idle(); issue(4, 15, 1, 16, 1, 17, 1);
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL full_fifth_blocked: got %0b want 0", issue_ready_o);
        end
        commit_valid_i = 1; commit_id_i = 4'd2; wb_valid_i = 1; wb_id_i = 4'd2;
        tick();
        commit_valid_i = 0; wb_valid_i = 0;
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL full_slot_freed: got %0b want 1", issue_ready_o);
        end
        tick();
        n_checks++;
        if (outstanding_o !== CNT_W'(4)) begin
            n_fail++; $display("FAIL full_refill: got out=%0d want 4", outstanding_o);
        end
        idle(); clear_i = 1;
        tick();
    endtask

    task automatic test_kill();
        idle(); issue(2, 5, 1, 0, 0, 0, 0);
        tick();
        idle(); commit_valid_i = 1; commit_id_i = 4'd2; commit_kill_i = 1;
        wb_valid_i = 1; wb_id_i = 4'd2;
        tick();
        n_checks++;
        if ({kill_valid_o, kill_id_o, err_o, outstanding_o} !== {1'b1, 4'd2, 1'b0, CNT_W'(0)}) begin
            n_fail++; $display("FAIL kill_pulse: got kv=%0b kid=%0d err=%0b out=%0d want 1 2 0 0",
                               kill_valid_o, kill_id_o, err_o, outstanding_o);
        end
        idle();
        tick();
        n_checks++;
        if (kill_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL kill_one_cycle: got kv=%0b want 0", kill_valid_o);
        end
    endtask

    task automatic test_unknown_id();
        idle(); wb_valid_i = 1; wb_id_i = 4'd5;
        tick();
        n_checks++;
        if ({err_o, outstanding_o} !== {1'b1, CNT_W'(0)}) begin
            n_fail++; $display("FAIL err_pulse: got err=%0b out=%0d want 1 0", err_o, outstanding_o);
        end
        idle();
        tick();
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++; $display("FAIL err_once: got err=%0b want 0", err_o);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            idle(); issue(8 + i, i, 1, 0, 0, 0, 0);
            tick();
        end
        idle(); clear_i = 1; issue(11, 7, 1, 0, 0, 0, 0);
        tick();
        n_checks++;
        if ({outstanding_o, busy_o, kill_valid_o} !== {CNT_W'(0), 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL clear_flush: got out=%0d busy=%0b kv=%0b want 0 0 0",
                               outstanding_o, busy_o, kill_valid_o);
        end
        // The dropped issue must not exist: a commit to it is unknown.
        idle(); commit_valid_i = 1; commit_id_i = 4'd11;
        tick();
        n_checks++;
        if ({err_o, outstanding_o} !== {1'b1, CNT_W'(0)}) begin
            n_fail++; $display("FAIL clear_drop_issue: got err=%0b out=%0d want 1 0", err_o, outstanding_o);
        end
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        idle(); issue(1, 1, 1, 0, 0, 0, 0);
        tick();
        idle(); issue(2, 2, 1, 0, 0, 0, 0);
        tick();
        idle();
        #2;
        rst_ni = 0;
        #1;
        n_checks++;
        if ({outstanding_o, busy_o, issue_ready_o} !== {CNT_W'(0), 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL async_reset: got out=%0d busy=%0b rdy=%0b want 0 0 1",
                               outstanding_o, busy_o, issue_ready_o);
        end
        q.delete();
        @(negedge clk_i);
        rst_ni = 1;
    endtask

    task automatic test_random();
        int   pick;
        logic [CNT_W+2:0] got, want;
        for (int n = 0; n < 400; n++) begin
            idle();
            issue_valid_i  = ($urandom_range(0, 3) != 0);
            issue_accept_i = ($urandom_range(0, 4) != 0);
            issue_id_i     = ID_W'($urandom_range(0, 7));
            issue_rd_i     = 5'($urandom_range(0, 7));
            issue_rs1_i    = 5'($urandom_range(0, 7));
            issue_rs2_i    = 5'($urandom_range(0, 7));
            issue_rd_we_i  = 1'($urandom_range(0, 1));
            issue_rs1_re_i = 1'($urandom_range(0, 1));
            issue_rs2_re_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                commit_valid_i = 1;
                pick = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                       q[$urandom_range(0, q.size() - 1)].id : int'($urandom_range(0, 15));
                commit_id_i   = ID_W'(pick);
                commit_kill_i = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 2) == 0) begin
                wb_valid_i = 1;
                pick = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                       q[$urandom_range(0, q.size() - 1)].id : int'($urandom_range(0, 15));
                wb_id_i = ID_W'(pick);
            end
            clear_i = ($urandom_range(0, 39) == 0);
            #1;
            n_checks++;
            if (issue_ready_o !== model_ready()) begin
                n_fail++; $display("FAIL rand_ready: cycle=%0d got %0b want %0b", n, issue_ready_o, model_ready());
            end
            tick();
            got  = {outstanding_o, busy_o, kill_valid_o, err_o};
            want = {CNT_W'(q.size()), q.size() != 0, exp_kill, exp_err};
            n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL rand_state: cycle=%0d got out/busy/kv/err=%b want %b", n, got, want);
            end
            if (exp_kill) begin
                n_checks++;
                if (kill_id_o !== ID_W'(exp_kill_id)) begin
                    n_fail++; $display("FAIL rand_kill_id: cycle=%0d got %0d want %0d", n, kill_id_o, exp_kill_id);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        @(posedge clk_i); #1;
        test_basic();
        test_raw_hazard();
        test_full();
        test_kill();
        test_unknown_id();
        test_clear();
        test_async_reset();
        @(posedge clk_i); #1;
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_xifu_ctrl.md
Name: fir_xifu_ctrl

Overview:
- In-flight instruction controller for the FIR XIFU coprocessor. Sits beside the decode stage and tracks every accepted xfirlw/xfirsw/xfirdotp in a small slot table.
- Drives issue_ready from the slot table and a register scoreboard, preventing RAW/WAW hazards on the XIFU's internal registers.
- Retires slots on core commit/kill and EX/WB completion; broadcasts kills so pipeline stages flush the matching instruction.

Parameters:
- N_SLOTS, 4, maximum outstanding instructions (2..8)
- ID_W, 4, width of XIF instruction id
- NREG, 32, XIFU internal register count (index width 5)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous flush of all slots
- issue_valid_i  in  1  XIF issue request valid
- issue_accept_i  in  1  decoder recognises the instruction as XIFU
- issue_id_i  in  ID_W  request id
- issue_rd_i / issue_rs1_i / issue_rs2_i  in  5 each  XIFU register indices
- issue_rd_we_i / issue_rs1_re_i / issue_rs2_re_i  in  1 each  index is used
- issue_ready_o  out  1  XIF issue_ready
- commit_valid_i  in  1  XIF commit valid
- commit_id_i  in  ID_W  committed id
- commit_kill_i  in  1  commit is a kill
- wb_valid_i  in  1  datapath finished an instruction
- wb_id_i  in  ID_W  finished id
- kill_valid_o  out  1  flush pulse to ID/EX/WB
- kill_id_o  out  ID_W  id to flush
- outstanding_o  out  $clog2(N_SLOTS+1)  non-FREE slot count
- busy_o  out  1  outstanding_o != 0
- err_o  out  1  one-cycle pulse on commit/wb to an unknown id

Behaviour:
- Reset: all slots FREE. issue_ready_o=1, kill_valid_o=0, kill_id_o=0, outstanding_o=0, busy_o=0, err_o=0.
- Slot fields: state {FREE, ISSUED, COMMITTED, DONE}, id, rd, rd_we.
- Allocation: on issue_valid_i & issue_accept_i & issue_ready_o, the lowest-index FREE slot becomes ISSUED and captures id, rd and rd_we.
- issue_ready_o is combinational from the registered slot state and the request fields. It is 0 when any of the following holds:
  - no slot is FREE;
  - a non-FREE slot has the same id;
  - a non-FREE slot with rd_we matches a used rs1, rs2 or rd (RAW/WAW).
  - Otherwise it is 1, including when issue_valid_i=0 or issue_accept_i=0.
- Slots freed in cycle t become available to issue in cycle t+1. There is no same-cycle bypass.
- Slot transitions:
  - ISSUED + commit (no kill) -> COMMITTED
  - ISSUED + wb -> DONE
  - ISSUED + commit & wb in the same cycle -> FREE
  - COMMITTED + wb -> FREE
  - DONE + commit (no kill) -> FREE
  - any non-FREE + commit_kill -> FREE
- Kill: the cycle after a kill of a known id, kill_valid_o=1 and kill_id_o=id for exactly one cycle. A kill wins over a simultaneous wb on the same id.
- Unknown id on commit or wb: no state change, err_o pulses the next cycle. A commit and a wb in the same cycle to different ids are both processed.
- clear_i: all slots go FREE next cycle and no kill pulse is generated. clear_i wins over every other event. An issue handshake in the same cycle as clear_i is dropped.
- Asynchronous reset mid-operation: immediate return to reset values.
- outstanding_o and busy_o are registered, reflecting post-update state.

Decomposition:
- fir_xifu_pkg gains:
  - fir_xifu_slot_state_e (FREE, ISSUED, COMMITTED, DONE), 2 bits;
  - fir_xifu_slot_t {state, id, rd, rd_we};
  - localparam XIFU_NSLOTS_DEF=4.
- Sub-module fir_xifu_scoreboard holds the combinational hazard and full check (slot array plus request in, ready out). Slot update logic stays in fir_xifu_ctrl.

Test Plan:
- Reset, then issue id=1 (xfirdotp, rd=3, rs1=1, rs2=2) -> issue_ready_o=1, outstanding_o=1 next cycle; commit id=1, then wb id=1 -> outstanding_o=0.
- Outstanding rd=3; issue rs1=3 -> issue_ready_o=0 until wb+commit of that slot, then 1 one cycle later.
- Issue ids 0..3 with disjoint registers -> fourth accepted, fifth (id=4) sees issue_ready_o=0; any slot freed -> id=4 accepted the next cycle.
- Issue id=2, kill id=2 with wb id=2 in the same cycle -> kill_valid_o=1, kill_id_o=2 for one cycle; slot FREE; err_o=0.
- wb id=5 with no slot outstanding -> err_o pulses once, outstanding_o unchanged.
- Three outstanding slots, assert clear_i with a simultaneous issue -> outstanding_o=0 next cycle, no kill_valid_o, new issue not recorded.
